// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8/SCHIP sprite engine: FSM encoding, screen geometries and a
// constant-evaluable log2 helper used to size coordinate ports.
package chip8_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAW  = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CHIP8_SCR_W    = 64;
    localparam int CHIP8_SCR_H    = 32;
    localparam int SCHIP_SCR_W    = 128;
    localparam int SCHIP_SCR_H    = 64;
    localparam int CHIP8_SPRITE_W = 8;
    localparam int SCHIP_SPRITE_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/chip8_row_blit.sv
// Combinational XOR of one sprite row into one framebuffer line, with right-edge clip or wrap,
// reporting whether any lit pixel was turned off.
module chip8_row_blit
    import chip8_pkg::*;
#(
    parameter int SCR_W     = 64,
    parameter int SCR_H     = 32,
    parameter int SPRITE_W  = 8,
    parameter int WRAP_MODE = 0
) (
    input  logic [SCR_W*SCR_H-1:0]    i_fb,
    input  logic [clog2(SCR_H)-1:0]   i_line,
    input  logic [clog2(SCR_W)-1:0]   i_x0,
    input  logic [SPRITE_W-1:0]       i_row_data,
    output logic [SCR_W-1:0]          o_row,
    output logic                      o_row_collision
);

    localparam int COL_W = clog2(SCR_W);

    logic [SCR_W-1:0] w_old_row;
    logic [COL_W:0]   w_col_full;
    logic [COL_W-1:0] w_col;
    logic             w_col_ok;
    logic             w_hit;

    assign w_old_row = i_fb[i_line*SCR_W +: SCR_W];

    // Walk the sprite bits MSB-first; the extra column bit flags pixels past the right edge.
    always_comb begin
        o_row           = w_old_row;
        o_row_collision = 1'b0;
        w_col_full      = '0;
        w_col           = '0;
        w_col_ok        = 1'b0;
        w_hit           = 1'b0;
        for (int i = 0; i < SPRITE_W; i++) begin
            w_col_full      = {1'b0, i_x0} + (COL_W+1)'(i);
            w_col           = w_col_full[COL_W-1:0];
            w_col_ok        = (WRAP_MODE != 0) ? 1'b1 : ~w_col_full[COL_W];
            w_hit           = w_col_ok & i_row_data[SPRITE_W-1-i];
            o_row_collision = o_row_collision | (w_hit & w_old_row[w_col]);
            o_row[w_col]    = o_row[w_col] ^ w_hit;
        end
    end

endmodule

// File: rtl/chip8_sprite_engine.sv
// Multi-row sprite draw / clear engine: fetches sprite rows over a req/ack port and XORs them
// into a register framebuffer exposed for scan-out, tracking collision over the whole sprite.
module chip8_sprite_engine
    import chip8_pkg::*;
#(
    parameter int SCR_W     = 64,
    parameter int SCR_H     = 32,
    parameter int SPRITE_W  = 8,
    parameter int ADDR_W    = 12,
    parameter int WRAP_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      clear,
    input  logic [clog2(SCR_W)-1:0]   x,
    input  logic [clog2(SCR_H)-1:0]   y,
    input  logic [4:0]                n_rows,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [SPRITE_W-1:0]       mem_rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      collision,
    output logic [SCR_W*SCR_H-1:0]    fb_out
);

    localparam int COL_W  = clog2(SCR_W);
    localparam int LINE_W = clog2(SCR_H);
    localparam int LS_W   = LINE_W + 5;

    logic [2:0]             r_state;
    logic [COL_W-1:0]       r_x0;
    logic [LINE_W-1:0]      r_y0;
    logic [4:0]             r_n_rows;
    logic [ADDR_W-1:0]      r_base;
    logic [4:0]             r_row;
    logic [SPRITE_W-1:0]    r_row_data;
    logic [SCR_W*SCR_H-1:0] r_fb;
    logic                   r_mem_req;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_collision;

    logic [2:0]             w_next_state;
    logic                   w_accept;
    logic                   w_last_row;
    logic [LS_W-1:0]        w_line_sum;
    logic                   w_line_ok;
    logic [LINE_W-1:0]      w_line;
    logic [SCR_W-1:0]       w_new_row;
    logic                   w_row_collision;

    assign w_accept   = (r_state == S_IDLE) && !clear && start;
    assign w_last_row = (r_row == (r_n_rows - 5'd1));
    assign w_line_sum = LS_W'(r_y0) + LS_W'(r_row);
    // In clip mode a line below the screen is dropped entirely rather than folded back.
    assign w_line_ok  = (WRAP_MODE != 0) || (w_line_sum < LS_W'(SCR_H));
    assign w_line     = w_line_sum[LINE_W-1:0];

    chip8_row_blit #(
        .SCR_W     (SCR_W),
        .SCR_H     (SCR_H),
        .SPRITE_W  (SPRITE_W),
        .WRAP_MODE (WRAP_MODE)
    ) u_row_blit (
        .i_fb            (r_fb),
        .i_line          (w_line),
        .i_x0            (r_x0),
        .i_row_data      (r_row_data),
        .o_row           (w_new_row),
        .o_row_collision (w_row_collision)
    );

    // Next-state decode; clear wins over start in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_next_state = S_CLEAR;
                end else if (start) begin
                    w_next_state = (n_rows == 5'd0) ? S_DONE : S_FETCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    w_next_state = S_DRAW;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DRAW: begin
                if (w_last_row) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_CLEAR: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Control state, registered status outputs, latched operands and fetch address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_n_rows    <= 5'd0;
            r_base      <= '0;
            r_row       <= 5'd0;
            r_row_data  <= '0;
            r_collision <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
            r_mem_req <= (w_next_state == S_FETCH);
            if (w_accept) begin
                r_x0        <= x;
                r_y0        <= y;
                r_n_rows    <= n_rows;
                r_base      <= base_addr;
                r_row       <= 5'd0;
                r_mem_addr  <= base_addr;
                r_collision <= 1'b0;
            end else if ((r_state == S_FETCH) && mem_ack) begin
                r_row_data <= mem_rdata;
            end else if (r_state == S_DRAW) begin
                r_collision <= r_collision | (w_line_ok & w_row_collision);
                if (!w_last_row) begin
                    r_row      <= r_row + 5'd1;
                    r_mem_addr <= r_base + ADDR_W'(r_row + 5'd1);
                end
            end
        end
    end

    // Framebuffer: whole-screen clear, or one line rewritten per DRAW cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb <= '0;
        end else if (r_state == S_CLEAR) begin
            r_fb <= '0;
        end else if ((r_state == S_DRAW) && w_line_ok) begin
            r_fb[w_line*SCR_W +: SCR_W] <= w_new_row;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign collision = r_collision;
    assign fb_out    = r_fb;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Directed bench for chip8_sprite_engine: 64x32 wrap and clip instances in lockstep, plus a
// 128x64 16-wide wrap instance; a memory responder answers fetches with a programmable delay.
module tb_chip8_sprite_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, clear, start_c;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [4:0]  n_rows;
    logic [11:0] base_addr;
    logic [6:0]  x_c;
    logic [5:0]  y_c;
    logic        ack_a, ack_c;
    logic [7:0]  rdata_a;
    logic [15:0] rdata_c;

    logic          req_a, busy_a, done_a, coll_a;
    logic [11:0]   addr_a;
    logic [2047:0] fb_a;
    logic          req_b, busy_b, done_b, coll_b;
    logic [11:0]   addr_b;
    logic [2047:0] fb_b;
    logic          req_c, busy_c, done_c, coll_c;
    logic [11:0]   addr_c;
    logic [8191:0] fb_c;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 0;
    bit addr_unstable = 1'b0;

    logic [7:0]    mem_a [0:4095];
    logic [15:0]   mem_c [0:4095];
    logic [2047:0] exp_a, exp_b;
    logic [8191:0] exp_c;

    chip8_sprite_engine #(.SCR_W(64), .SCR_H(32), .SPRITE_W(8), .ADDR_W(12), .WRAP_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .x(x), .y(y), .n_rows(n_rows),
        .base_addr(base_addr), .mem_req(req_a), .mem_addr(addr_a), .mem_ack(ack_a),
        .mem_rdata(rdata_a), .busy(busy_a), .done(done_a), .collision(coll_a), .fb_out(fb_a));

    chip8_sprite_engine #(.SCR_W(64), .SCR_H(32), .SPRITE_W(8), .ADDR_W(12), .WRAP_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .x(x), .y(y), .n_rows(n_rows),
        .base_addr(base_addr), .mem_req(req_b), .mem_addr(addr_b), .mem_ack(ack_a),
        .mem_rdata(rdata_a), .busy(busy_b), .done(done_b), .collision(coll_b), .fb_out(fb_b));

    chip8_sprite_engine #(.SCR_W(128), .SCR_H(64), .SPRITE_W(16), .ADDR_W(12), .WRAP_MODE(1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .clear(clear), .x(x_c), .y(y_c), .n_rows(n_rows),
        .base_addr(base_addr), .mem_req(req_c), .mem_addr(addr_c), .mem_ack(ack_c),
        .mem_rdata(rdata_c), .busy(busy_c), .done(done_c), .collision(coll_c), .fb_out(fb_c));

    // Memory responder for the 64x32 pair: acks after ack_delay waiting cycles, watches addr.
    initial begin
        int cnt;
        logic [11:0] prev;
        cnt = 0; prev = 12'd0; ack_a = 1'b0; rdata_a = 8'd0;
        forever begin
            @(negedge clk);
            if (req_a) begin
                if (cnt > 0 && addr_a !== prev) addr_unstable = 1'b1;
                prev = addr_a;
                if (cnt >= ack_delay) begin
                    ack_a = 1'b1; rdata_a = mem_a[addr_a];
                end else begin
                    ack_a = 1'b0;
                end
                cnt++;
            end else begin
                ack_a = 1'b0; cnt = 0;
            end
        end
    end

    // Memory responder for the hi-res instance.
    initial begin
        int cnt;
        cnt = 0; ack_c = 1'b0; rdata_c = 16'd0;
        forever begin
            @(negedge clk);
            if (req_c) begin
                if (cnt >= ack_delay) begin
                    ack_c = 1'b1; rdata_c = mem_c[addr_c];
                end else begin
                    ack_c = 1'b0;
                end
                cnt++;
            end else begin
                ack_c = 1'b0; cnt = 0;
            end
        end
    end

    function automatic int first_diff(input logic [8191:0] a, input logic [8191:0] b);
        for (int i = 0; i < 8192; i++) if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    // Issue start and/or clear at a negedge; report the cycle done appears in (start cycle = 1).
    task automatic run_op(input bit use_c, input logic s, input logic c, input bit poke,
                          output int done_cyc, output bit saw_req, output bit stuck);
        done_cyc = -1; saw_req = 1'b0; stuck = 1'b0;
        if (use_c) start_c = s; else start = s;
        clear = c;
        @(posedge clk); #1;
        start = 1'b0; start_c = 1'b0; clear = 1'b0;
        for (int cyc = 2; cyc < 200; cyc++) begin
            @(negedge clk);
            if (use_c ? req_c : req_a) saw_req = 1'b1;
            if (use_c ? done_c : done_a) begin
                start = 1'b0; done_cyc = cyc; break;
            end else if (poke) begin
                start = (cyc % 2 == 0);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        stuck = use_c ? (done_c | busy_c) : (done_a | busy_a);
    endtask

    task automatic set_glyph_expect();
        int bits [14] = '{0, 1, 2, 3, 64, 67, 128, 131, 192, 195, 256, 257, 258, 259};
        exp_a = '0;
        foreach (bits[i]) exp_a[bits[i]] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy_a, done_a, req_a, coll_a} !== 4'b0000 || addr_a !== 12'd0) begin
            n_err++; $display("FAIL reset_ctrl: busy/done/req/coll=%b addr=%h want 0000/000",
                              {busy_a, done_a, req_a, coll_a}, addr_a);
        end
        n_vec++;
        if (fb_a !== '0 || fb_c !== '0) begin
            n_err++; $display("FAIL reset_fb: ones a=%0d c=%0d want 0", $countones(fb_a), $countones(fb_c));
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_glyph(input bit second);
        int dc; bit sr, st, d;
        x = 6'd0; y = 5'd0; n_rows = 5'd5; base_addr = 12'h200; ack_delay = 0;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, dc, sr, st);
        if (second) exp_a = '0; else set_glyph_expect();
        n_vec++;
        if (dc !== 12) begin n_err++; $display("FAIL glyph_latency: done at cycle %0d want 12", dc); end
        n_vec++;
        if (fb_a !== exp_a) begin
            d = 1'b0; n_err++;
            $display("FAIL glyph_fb: bit %0d got %b want %b", first_diff(fb_a, exp_a),
                     fb_a[first_diff(fb_a, exp_a)], exp_a[first_diff(fb_a, exp_a)]);
        end
        n_vec++;
        if (coll_a !== second) begin n_err++; $display("FAIL glyph_collision: got %b want %b", coll_a, second); end
        n_vec++;
        if (st !== 1'b0) begin n_err++; $display("FAIL glyph_done_pulse: done/busy still high after done"); end
        n_vec++;
        if (fb_b !== exp_a) begin n_err++; $display("FAIL glyph_fb_clip: ones got %0d want %0d", $countones(fb_b), $countones(exp_a)); end
    endtask

    task automatic test_zero_rows();
        int dc; bit sr, st;
        n_rows = 5'd0; base_addr = 12'h200;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, dc, sr, st);
        n_vec++;
        if (dc !== 2) begin n_err++; $display("FAIL zero_latency: done at cycle %0d want 2", dc); end
        n_vec++;
        if (sr !== 1'b0) begin n_err++; $display("FAIL zero_no_fetch: mem_req seen %b want 0", sr); end
        n_vec++;
        if (coll_a !== 1'b0) begin n_err++; $display("FAIL zero_collision: got %b want 0", coll_a); end
    endtask

    task automatic test_wrap();
        int dc; bit sr, st;
        x = 6'd60; y = 5'd31; n_rows = 5'd2; base_addr = 12'h300; ack_delay = 0;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, dc, sr, st);
        exp_a = '0; exp_b = '0;
        for (int c = 60; c < 64; c++) begin
            exp_a[1984 + c] = 1'b1; exp_a[c] = 1'b1; exp_b[1984 + c] = 1'b1;
        end
        for (int c = 0; c < 4; c++) begin
            exp_a[1984 + c] = 1'b1; exp_a[c] = 1'b1;
        end
        n_vec++;
        if (dc !== 6) begin n_err++; $display("FAIL wrap_latency: done at cycle %0d want 6", dc); end
        n_vec++;
        if (fb_a !== exp_a) begin
            n_err++; $display("FAIL wrap_fb: bit %0d got %b want %b", first_diff(fb_a, exp_a),
                              fb_a[first_diff(fb_a, exp_a)], exp_a[first_diff(fb_a, exp_a)]);
        end
        n_vec++;
        if (fb_b !== exp_b) begin
            n_err++; $display("FAIL clip_fb: bit %0d got %b want %b", first_diff(fb_b, exp_b),
                              fb_b[first_diff(fb_b, exp_b)], exp_b[first_diff(fb_b, exp_b)]);
        end
        n_vec++;
        if (coll_a !== 1'b0 || coll_b !== 1'b0) begin
            n_err++; $display("FAIL wrap_collision: got %b %b want 0 0", coll_a, coll_b);
        end
    endtask

    task automatic test_clear_priority();
        int dc; bit sr, st;
        x = 6'd0; y = 5'd0; n_rows = 5'd5; base_addr = 12'h200;
        run_op(1'b0, 1'b1, 1'b1, 1'b0, dc, sr, st);
        n_vec++;
        if (dc !== 3) begin n_err++; $display("FAIL clear_latency: done at cycle %0d want 3", dc); end
        n_vec++;
        if (sr !== 1'b0) begin n_err++; $display("FAIL clear_no_fetch: mem_req seen %b want 0", sr); end
        n_vec++;
        if (fb_a !== '0 || fb_b !== '0) begin
            n_err++; $display("FAIL clear_fb: ones a=%0d b=%0d want 0", $countones(fb_a), $countones(fb_b));
        end
        n_vec++;
        if (coll_a !== 1'b0) begin n_err++; $display("FAIL clear_collision: got %b want 0", coll_a); end
    endtask

    task automatic test_wait_state();
        int dc; bit sr, st;
        x = 6'd8; y = 5'd4; n_rows = 5'd3; base_addr = 12'h400; ack_delay = 3; addr_unstable = 1'b0;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, dc, sr, st);
        exp_a = '0;
        exp_a[264] = 1'b1; exp_a[271] = 1'b1;
        exp_a[329] = 1'b1; exp_a[334] = 1'b1;
        exp_a[394] = 1'b1; exp_a[397] = 1'b1;
        n_vec++;
        if (dc !== 17) begin n_err++; $display("FAIL wait_latency: done at cycle %0d want 17", dc); end
        n_vec++;
        if (fb_a !== exp_a) begin
            n_err++; $display("FAIL wait_fb: bit %0d got %b want %b", first_diff(fb_a, exp_a),
                              fb_a[first_diff(fb_a, exp_a)], exp_a[first_diff(fb_a, exp_a)]);
        end
        n_vec++;
        if (addr_unstable !== 1'b0) begin n_err++; $display("FAIL wait_addr_stable: addr moved while req high"); end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_draw();
        bit found;
        x = 6'd0; y = 5'd0; n_rows = 5'd4; base_addr = 12'h600; ack_delay = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_a && addr_a == 12'h602) begin found = 1'b1; break; end
        end
        n_vec++;
        if (found !== 1'b1 || fb_a[71:64] !== 8'hFF) begin
            n_err++; $display("FAIL midreset_reach: row2 found=%b line1=%h want 1 ff", found, fb_a[71:64]);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (busy_a !== 1'b0 || req_a !== 1'b0 || fb_a !== '0) begin
            n_err++; $display("FAIL midreset_abort: busy=%b req=%b fb ones=%0d want 0 0 0", busy_a, req_a, $countones(fb_a));
        end
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        test_glyph(1'b0);
    endtask

    task automatic test_schip();
        int dc; bit sr, st;
        x_c = 7'd120; y_c = 6'd3; n_rows = 5'd1; base_addr = 12'h500; ack_delay = 0;
        run_op(1'b1, 1'b1, 1'b0, 1'b0, dc, sr, st);
        exp_c = '0; exp_c[504] = 1'b1; exp_c[391] = 1'b1;
        n_vec++;
        if (dc !== 4) begin n_err++; $display("FAIL schip_latency: done at cycle %0d want 4", dc); end
        n_vec++;
        if (fb_c !== exp_c) begin
            n_err++; $display("FAIL schip_fb: bit %0d got %b want %b", first_diff(fb_c, exp_c),
                              fb_c[first_diff(fb_c, exp_c)], exp_c[first_diff(fb_c, exp_c)]);
        end
        n_vec++;
        if (coll_c !== 1'b0) begin n_err++; $display("FAIL schip_collision: got %b want 0", coll_c); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0; start_c = 1'b0;
        x = 6'd0; y = 5'd0; n_rows = 5'd0; base_addr = 12'd0; x_c = 7'd0; y_c = 6'd0;
        for (int i = 0; i < 4096; i++) begin mem_a[i] = 8'h00; mem_c[i] = 16'h0000; end
        mem_a[12'h200] = 8'hF0; mem_a[12'h201] = 8'h90; mem_a[12'h202] = 8'h90;
        mem_a[12'h203] = 8'h90; mem_a[12'h204] = 8'hF0;
        mem_a[12'h300] = 8'hFF; mem_a[12'h301] = 8'hFF;
        mem_a[12'h400] = 8'h81; mem_a[12'h401] = 8'h42; mem_a[12'h402] = 8'h24;
        for (int i = 0; i < 4; i++) mem_a[12'h600 + i] = 8'hFF;
        mem_c[12'h500] = 16'h8001;
        test_reset();
        test_glyph(1'b0);
        test_glyph(1'b1);
        test_zero_rows();
        test_wrap();
        test_clear_priority();
        test_wait_state();
        test_reset_mid_draw();
        test_schip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
